// File: rtl/pcs_transmit_pkg.sv
// Shared constants for the 1000BASE-X PCS transmit path: K/D byte values,
// RD- code-group forms (RD+ is the bitwise complement) and one-hot FSM states.
package pcs_transmit_pkg;

  typedef enum logic [5:0] {
    ST_IDLE_K = 6'b000001,
    ST_IDLE_D = 6'b000010,
    ST_SOP    = 6'b000100,
    ST_DATA   = 6'b001000,
    ST_EPD2   = 6'b010000,
    ST_EPD3   = 6'b100000
  } tx_state_e;

  // Byte values fed to the encoder
  localparam logic [7:0] K28_5_B = 8'hBC;
  localparam logic [7:0] K27_7_B = 8'hFB;  // /S/
  localparam logic [7:0] K29_7_B = 8'hFD;  // /T/
  localparam logic [7:0] K23_7_B = 8'hF7;  // /R/
  localparam logic [7:0] K30_7_B = 8'hFE;  // /V/
  localparam logic [7:0] D5_6_B  = 8'hC5;
  localparam logic [7:0] D16_2_B = 8'h50;

  // Code-groups, bit order abcdei_fghj with [9]=a
  localparam logic [9:0] K28_5_N = 10'b001111_1010;
  localparam logic [9:0] K28_5_P = ~K28_5_N;
  localparam logic [9:0] S_N     = 10'b110110_1000;
  localparam logic [9:0] S_P     = ~S_N;
  localparam logic [9:0] T_N     = 10'b101110_1000;
  localparam logic [9:0] T_P     = ~T_N;
  localparam logic [9:0] R_N     = 10'b111010_1000;
  localparam logic [9:0] R_P     = ~R_N;
  localparam logic [9:0] V_N     = 10'b011110_1000;
  localparam logic [9:0] V_P     = ~V_N;
  localparam logic [9:0] D5_6    = 10'b101001_0110;
  localparam logic [9:0] D16_2_N = 10'b011011_0101;
  localparam logic [9:0] D16_2_P = 10'b100100_0101;

  // Only the control characters this PCS emits; anything else maps to K28.5.
  function automatic logic [9:0] k_code_n(input logic [7:0] b);
    logic [9:0] c;
    c = K28_5_N;
    case (b)
      K27_7_B: c = S_N;
      K29_7_B: c = T_N;
      K23_7_B: c = R_N;
      K30_7_B: c = V_N;
      default: c = K28_5_N;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pcs_transmit_encoder.sv
// Combinational 8b/10b encoder: full 5b/6b + 3b/4b data tables with the A7
// alternate, plus the K codes used by the transmit FSM.
module encoder_8b10b
  import pcs_transmit_pkg::*;
(
  input  logic [7:0] data,
  input  logic       is_k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] s6, c6;
  logic [3:0] s4, c4;
  logic [9:0] kn;
  logic       bal6, bal4, balk, rd6, alt7;

  assign x = data[4:0];
  assign y = data[7:5];

  // 5b/6b, RD- column
  always_comb begin
    s6 = 6'b100111;
    case (x)
      5'd0:  s6 = 6'b100111;
      5'd1:  s6 = 6'b011101;
      5'd2:  s6 = 6'b101101;
      5'd3:  s6 = 6'b110001;
      5'd4:  s6 = 6'b110101;
      5'd5:  s6 = 6'b101001;
      5'd6:  s6 = 6'b011001;
      5'd7:  s6 = 6'b111000;
      5'd8:  s6 = 6'b111001;
      5'd9:  s6 = 6'b100101;
      5'd10: s6 = 6'b010101;
      5'd11: s6 = 6'b110100;
      5'd12: s6 = 6'b001101;
      5'd13: s6 = 6'b101100;
      5'd14: s6 = 6'b011100;
      5'd15: s6 = 6'b010111;
      5'd16: s6 = 6'b011011;
      5'd17: s6 = 6'b100011;
      5'd18: s6 = 6'b010011;
      5'd19: s6 = 6'b110010;
      5'd20: s6 = 6'b001011;
      5'd21: s6 = 6'b101010;
      5'd22: s6 = 6'b011010;
      5'd23: s6 = 6'b111010;
      5'd24: s6 = 6'b110011;
      5'd25: s6 = 6'b100110;
      5'd26: s6 = 6'b010110;
      5'd27: s6 = 6'b110110;
      5'd28: s6 = 6'b001110;
      5'd29: s6 = 6'b101110;
      5'd30: s6 = 6'b011110;
      default: s6 = 6'b101011;
    endcase
  end

  assign bal6 = ($countones(s6) == 3);
  assign c6   = (rd_in && (!bal6 || x == 5'd7)) ? ~s6 : s6;
  assign rd6  = rd_in ^ !bal6;
  // A7 avoids a run of five identical bits across the sub-block boundary
  assign alt7 = rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                    : (x == 5'd17 || x == 5'd18 || x == 5'd20);

  always_comb begin
    s4 = 4'b1011;
    case (y)
      3'd0: s4 = 4'b1011;
      3'd1: s4 = 4'b1001;
      3'd2: s4 = 4'b0101;
      3'd3: s4 = 4'b1100;
      3'd4: s4 = 4'b1101;
      3'd5: s4 = 4'b1010;
      3'd6: s4 = 4'b0110;
      default: s4 = alt7 ? 4'b0111 : 4'b1110;
    endcase
  end

  assign bal4 = ($countones(s4) == 2);
  assign c4   = (rd6 && (!bal4 || y == 3'd3)) ? ~s4 : s4;

  assign kn   = k_code_n(data);
  assign balk = ($countones(kn) == 5);

  assign code   = is_k ? (rd_in ? ~kn : kn) : {c6, c4};
  assign rd_out = is_k ? (rd_in ^ !balk) : (rd6 ^ !bal4);

endmodule

// File: rtl/pcs_transmit.sv
// 1000BASE-X PCS transmit: GMII bytes to 10-bit code-groups with /I/, /S/,
// /T/, /R/, /V/ framing, parity tracking and registered running disparity.
module pcs_transmit
  import pcs_transmit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txd,
  input  logic       tx_en,
  input  logic       tx_er,
  output logic [9:0] tx_code_group,
  output logic       tx_even,
  output logic       tx_rd
);

  tx_state_e  state_q, state_d;
  logic [9:0] code_q;
  logic       even_q, even_d;
  logic       rd_q;
  logic [7:0] enc_data;
  logic       enc_k;
  logic [9:0] enc_code;
  logic       enc_rd;

  encoder_8b10b u_enc (
    .data   (enc_data),
    .is_k   (enc_k),
    .rd_in  (rd_q),
    .code   (enc_code),
    .rd_out (enc_rd)
  );

  always_comb begin
    state_d  = state_q;
    enc_data = K28_5_B;
    enc_k    = 1'b1;
    even_d   = ~even_q;
    unique case (state_q)
      ST_IDLE_K: begin
        even_d  = 1'b1;
        state_d = ST_IDLE_D;
      end
      ST_IDLE_D: begin
        // RD+ here means RD- before the comma: D16.2 pulls it back to RD-
        enc_data = rd_q ? D16_2_B : D5_6_B;
        enc_k    = 1'b0;
        state_d  = tx_en ? ST_SOP : ST_IDLE_K;
      end
      ST_SOP: begin
        enc_data = K27_7_B;
        state_d  = ST_DATA;
      end
      ST_DATA: begin
        if (!tx_en) begin
          enc_data = K29_7_B;
          state_d  = ST_EPD2;
        end else if (tx_er) begin
          enc_data = K30_7_B;
        end else begin
          enc_data = txd;
          enc_k    = 1'b0;
        end
      end
      ST_EPD2: begin
        enc_data = K23_7_B;
        // even_d is this /R/'s parity; a second /R/ keeps /I/ on an even slot
        state_d  = even_d ? ST_EPD3 : ST_IDLE_K;
      end
      ST_EPD3: begin
        enc_data = K23_7_B;
        state_d  = ST_IDLE_K;
      end
      default: state_d = ST_IDLE_K;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE_K;
      code_q  <= '0;
      even_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= enc_code;
      even_q  <= even_d;
      rd_q    <= enc_rd;
    end
  end

  assign tx_code_group = code_q;
  assign tx_even       = even_q;
  assign tx_rd         = rd_q;

endmodule

// File: tb/tb_pcs_transmit.sv
// Scoreboard bench for pcs_transmit: a behavioural reference pushes the
// expected code-group/parity/RD each cycle; outputs are popped and compared.
module tb_pcs_transmit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] txd = 8'h00;
  logic       tx_en = 1'b0;
  logic       tx_er = 1'b0;
  logic [9:0] tx_code_group;
  logic       tx_even, tx_rd;

  typedef struct packed {
    logic [9:0] cg;
    logic       even;
    logic       rd;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_st = 0;   // 0 IK, 1 ID, 2 SOP, 3 DATA, 4 EPD2, 5 EPD3
  bit   m_rd = 0;
  bit   m_even = 0;
  bit   en_r = 0;
  int   guard;

  pcs_transmit dut (
    .clk           (clk),
    .reset         (reset),
    .txd           (txd),
    .tx_en         (tx_en),
    .tx_er         (tx_er),
    .tx_code_group (tx_code_group),
    .tx_even       (tx_even),
    .tx_rd         (tx_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] t6(input logic [4:0] x);
    case (x)
      0: return 6'b100111;  1: return 6'b011101;  2: return 6'b101101;  3: return 6'b110001;
      4: return 6'b110101;  5: return 6'b101001;  6: return 6'b011001;  7: return 6'b111000;
      8: return 6'b111001;  9: return 6'b100101; 10: return 6'b010101; 11: return 6'b110100;
     12: return 6'b001101; 13: return 6'b101100; 14: return 6'b011100; 15: return 6'b010111;
     16: return 6'b011011; 17: return 6'b100011; 18: return 6'b010011; 19: return 6'b110010;
     20: return 6'b001011; 21: return 6'b101010; 22: return 6'b011010; 23: return 6'b111010;
     24: return 6'b110011; 25: return 6'b100110; 26: return 6'b010110; 27: return 6'b110110;
     28: return 6'b001110; 29: return 6'b101110; 30: return 6'b011110; default: return 6'b101011;
    endcase
  endfunction

  // Reference encoder; RD after each sub-block is taken from the emitted bits.
  task automatic ref_enc(input logic [7:0] b, input bit k, input bit rd,
                         output logic [9:0] cg, output bit rdo);
    logic [9:0] kc;
    logic [5:0] c6;
    logic [3:0] c4;
    bit         r6, a7;
    int         x, y;
    if (k) begin
      case (b)
        8'hFB:   kc = 10'b1101101000;
        8'hFD:   kc = 10'b1011101000;
        8'hF7:   kc = 10'b1110101000;
        8'hFE:   kc = 10'b0111101000;
        default: kc = 10'b0011111010;
      endcase
      cg  = rd ? ~kc : kc;
      rdo = ($countones(cg) > 5) ? 1'b1 : ($countones(cg) < 5) ? 1'b0 : rd;
    end else begin
      x  = int'(b[4:0]);
      y  = int'(b[7:5]);
      c6 = t6(b[4:0]);
      if (rd && ($countones(c6) != 3 || x == 7)) c6 = ~c6;
      r6 = ($countones(c6) > 3) ? 1'b1 : ($countones(c6) < 3) ? 1'b0 : rd;
      a7 = r6 ? (x == 11 || x == 13 || x == 14) : (x == 17 || x == 18 || x == 20);
      case (y)
        0: c4 = 4'b1011; 1: c4 = 4'b1001; 2: c4 = 4'b0101; 3: c4 = 4'b1100;
        4: c4 = 4'b1101; 5: c4 = 4'b1010; 6: c4 = 4'b0110;
        default: c4 = a7 ? 4'b0111 : 4'b1110;
      endcase
      if (r6 && ($countones(c4) != 2 || y == 3)) c4 = ~c4;
      rdo = ($countones(c4) > 2) ? 1'b1 : ($countones(c4) < 2) ? 1'b0 : r6;
      cg  = {c6, c4};
    end
  endtask

  task automatic model(input bit rst_n, input bit en, input bit er, input logic [7:0] d);
    exp_t       e;
    logic [9:0] cg;
    logic [7:0] b;
    bit         r, k, ev;
    int         nx;
    if (!rst_n) begin
      m_st = 0; m_rd = 0; m_even = 0;
      e = '0;
      sb.push_back(e);
      return;
    end
    ev = !m_even; k = 1; b = 8'hBC; nx = m_st;
    case (m_st)
      0: begin ev = 1; nx = 1; end
      1: begin k = 0; b = m_rd ? 8'h50 : 8'hC5; nx = en ? 2 : 0; end
      2: begin b = 8'hFB; nx = 3; end
      3: if (!en) begin b = 8'hFD; nx = 4; end
         else if (er) b = 8'hFE;
         else begin k = 0; b = d; end
      4: begin b = 8'hF7; nx = ev ? 5 : 0; end
      default: begin b = 8'hF7; nx = 0; end
    endcase
    ref_enc(b, k, m_rd, cg, r);
    e.cg = cg; e.even = ev; e.rd = r;
    m_rd = r; m_even = ev; m_st = nx;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit rst_n, input bit en, input bit er, input logic [7:0] d);
    exp_t e;
    reset = rst_n; tx_en = en; tx_er = er; txd = d;
    model(rst_n, en, er, d);
    @(posedge clk);
    #1;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("cg", tx_code_group, e.cg);
      chk("even", tx_even, e.even);
      chk("rd", tx_rd, e.rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00);
    chk("rst_cg", tx_code_group, 10'd0);
    chk("rst_even", tx_even, 0);

    cyc(1, 0, 0, 8'h00);
    chk("first_k28_5", tx_code_group, 10'b001111_1010);
    chk("first_even", tx_even, 1);
    cyc(1, 0, 0, 8'h00);
    chk("idle_d16_2", tx_code_group, 10'b100100_0101);
    chk("idle_rd", tx_rd, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h00);

    // frame A: tx_en rises in IDLE_K, 4 x 0x00, /T/ lands odd
    cyc(1, 1, 0, 8'h55);
    cyc(1, 1, 0, 8'h55);
    cyc(1, 1, 0, 8'hD5);
    chk("sop", tx_code_group, 10'b110110_1000);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 8'h00);
      chk("d0_0", tx_code_group, 10'b100111_0100);
      chk("d0_0_rd", tx_rd, 0);
    end
    cyc(1, 0, 0, 8'h00);
    chk("t_odd", tx_code_group, 10'b101110_1000);
    cyc(1, 0, 0, 8'h00);
    chk("r1", tx_code_group, 10'b111010_1000);
    cyc(1, 0, 0, 8'h00);
    chk("r2", tx_code_group, 10'b111010_1000);
    cyc(1, 0, 0, 8'h00);
    chk("k_after_rr", tx_code_group, 10'b001111_1010);
    chk("k_after_rr_even", tx_even, 1);

    // frame B: starts in IDLE_D, 5 bytes so /T/ lands even -> T R I
    cyc(1, 1, 0, 8'h55);
    cyc(1, 1, 0, 8'hD5);
    cyc(1, 1, 0, 8'hA5); cyc(1, 1, 0, 8'h3C); cyc(1, 1, 0, 8'hF1);
    cyc(1, 1, 0, 8'h0B); cyc(1, 1, 0, 8'hEB);
    cyc(1, 0, 0, 8'h00);
    chk("t_even_par", tx_even, 1);
    cyc(1, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    chk("k_after_r_even", tx_even, 1);
    chk("k_after_r_k", {tx_code_group[9:4] == 6'b001111 || tx_code_group[9:4] == 6'b110000}, 1);

    // frame C: last byte 0x03 from RD- leaves RD+, so /I/ uses D5.6
    cyc(1, 1, 0, 8'h55);
    cyc(1, 1, 0, 8'hD5);
    cyc(1, 1, 0, 8'h03);
    chk("d3_0", tx_code_group, 10'b110001_1011);
    chk("d3_0_rd", tx_rd, 1);
    cyc(1, 0, 0, 8'h00);
    chk("t_rdp", tx_code_group, 10'b010001_0111);
    cyc(1, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    chk("k_rdp", tx_code_group, 10'b110000_0101);
    cyc(1, 0, 0, 8'h00);
    chk("i1_d5_6", tx_code_group, 10'b101001_0110);
    chk("i1_rd", tx_rd, 0);

    // frame D: one tx_er cycle mid-frame -> one /V/
    cyc(1, 1, 0, 8'h55);
    cyc(1, 1, 0, 8'h55);
    cyc(1, 1, 0, 8'hD5);
    cyc(1, 1, 0, 8'h00);
    cyc(1, 1, 1, 8'h00);
    chk("v_err", tx_code_group, 10'b011110_1000);
    cyc(1, 1, 0, 8'h00);
    chk("after_v", tx_code_group, 10'b100111_0100);
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 8'hFF);

    // randomised traffic, errors included
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) en_r = !en_r;
      cyc(1, en_r, ($urandom_range(0, 15) == 0), 8'($urandom));
    end

    // reset mid-frame
    guard = 0;
    while (m_st != 3 && guard < 12) begin
      cyc(1, 1, 0, 8'($urandom));
      guard++;
    end
    chk("reach_data", m_st, 3);
    cyc(0, 1, 0, 8'h12);
    chk("midrst_cg", tx_code_group, 10'd0);
    chk("midrst_even", tx_even, 0);
    chk("midrst_rd", tx_rd, 0);
    cyc(1, 1, 0, 8'h12);
    chk("post_rst_k", tx_code_group, 10'b001111_1010);
    chk("post_rst_even", tx_even, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
